// File: rtl/thor2024_wbq_pkg.sv
// ============================================================================
// thor2024_wbq_pkg : shared types and constants for the writeback queue
// Rev 1.0
// ============================================================================
`default_nettype none

package thor2024_wbq_pkg;

    localparam int NSRC     = 4;
    localparam int WBQ_WID  = 64;
    localparam int WBQ_TAGW = 12;
    localparam logic [5:0] R0_MASK = 6'h3F;

    typedef struct packed {
        logic [WBQ_TAGW-1:0] tag;
        logic [7:0]          we;
        logic [WBQ_WID-1:0]  dat;
    } wbq_entry_t;

    // Writes to r0 are architecturally dropped, so they never occupy a slot.
    function automatic logic is_r0(input logic [WBQ_TAGW-1:0] tag);
        return (tag[5:0] & R0_MASK) == 6'h00;
    endfunction

endpackage

`default_nettype wire

// File: rtl/thor2024_wbq_compact.sv
// ============================================================================
// thor2024_wbq_compact : packs accepted, non-r0 source entries in index order
// Rev 1.0
// ============================================================================
`default_nettype none

module thor2024_wbq_compact
    import thor2024_wbq_pkg::*;
(
    input  logic [NSRC-1:0] acc,
    input  wbq_entry_t      in_ent  [NSRC],
    output wbq_entry_t      out_ent [NSRC],
    output logic [2:0]      n
);

    always_comb begin
        out_ent = '{default: '0};
        n       = 3'd0;
        for (int k = 0; k < NSRC; k++) begin
            if (acc[k] && !is_r0(in_ent[k].tag)) begin
                out_ent[n[1:0]] = in_ent[k];
                n               = n + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/thor2024_wb_queue.sv
// ============================================================================
// thor2024_wb_queue : 4-source writeback staging queue, 2 write ports drained
// Optional macro THOR2024_WBQ_BYPASS_EN: empty-queue bypass to output regs.
// Rev 1.0
// ============================================================================
`default_nettype none

module thor2024_wb_queue #(
    parameter int WID   = 64,
    parameter int RBIT  = 11,
    parameter int DEPTH = 16,
    parameter int NSRC  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NSRC-1:0]          src_v,
    output logic [NSRC-1:0]          src_rdy,
    input  logic [NSRC*(RBIT+1)-1:0] src_tag,
    input  logic [NSRC*8-1:0]        src_we,
    input  logic [NSRC*WID-1:0]      src_dat,
    output logic                     wr0,
    output logic                     wr1,
    output logic [7:0]               we0,
    output logic [7:0]               we1,
    output logic [RBIT:0]            wa0,
    output logic [RBIT:0]            wa1,
    output logic [WID-1:0]           i0,
    output logic [WID-1:0]           i1,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    import thor2024_wbq_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = RBIT + 1;

    if (WID != WBQ_WID || TW != WBQ_TAGW || NSRC != 4) begin : g_param_err
        $error("thor2024_wb_queue: WID/RBIT/NSRC must match thor2024_wbq_pkg");
    end

    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    wbq_entry_t      r_mem [DEPTH];

    wbq_entry_t      w_in  [4];
    wbq_entry_t      w_cmp [4];
    wbq_entry_t      w_o0;
    wbq_entry_t      w_o1;
    logic [2:0]      w_n;
    logic [2:0]      w_nbyp;
    logic [2:0]      w_nq;
    logic [1:0]      w_pop;
    logic            w_rdy;
    logic            w_byp;
    logic            w_v0;
    logic            w_v1;
    logic [3:0]      w_acc;

    // One shared ready: room for a full 4-wide burst in the worst case.
    assign w_rdy   = rst_n && (r_count <= CW'(DEPTH - NSRC));
    assign src_rdy = {NSRC{w_rdy}};
    assign w_acc   = src_v & src_rdy;

    for (genvar k = 0; k < 4; k++) begin : g_src
        assign w_in[k] = {src_tag[k*TW +: TW], src_we[k*8 +: 8], src_dat[k*WID +: WID]};
    end

    thor2024_wbq_compact u_compact (
        .acc     (w_acc),
        .in_ent  (w_in),
        .out_ent (w_cmp),
        .n       (w_n)
    );

`ifdef THOR2024_WBQ_BYPASS_EN
    assign w_byp = (r_count == '0);
`else
    assign w_byp = 1'b0;
`endif

    assign w_pop  = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
    assign w_nbyp = w_byp ? ((w_n > 3'd2) ? 3'd2 : w_n) : 3'd0;
    assign w_nq   = w_n - w_nbyp;

    always_comb begin
        w_o0 = r_mem[r_head];
        w_o1 = r_mem[r_head + PW'(1)];
        w_v0 = (w_pop != 2'd0);
        w_v1 = (w_pop == 2'd2);
        if (w_byp) begin
            w_o0 = w_cmp[0];
            w_o1 = w_cmp[1];
            w_v0 = (w_n >= 3'd1);
            w_v1 = (w_n >= 3'd2);
        end
    end

    // Storage needs no reset; validity is carried by head/tail/count.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_nq) begin
                r_mem[r_tail + PW'(k)] <= w_cmp[2'(k + int'(w_nbyp))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            wr0     <= 1'b0;
            wr1     <= 1'b0;
            we0     <= 8'h00;
            we1     <= 8'h00;
            wa0     <= '0;
            wa1     <= '0;
            i0      <= '0;
            i1      <= '0;
        end else begin
            r_head  <= r_head + PW'(w_pop);
            r_tail  <= r_tail + PW'(w_nq);
            r_count <= r_count + CW'(w_nq) - CW'(w_pop);
            wr0     <= w_v0;
            wr1     <= w_v1;
            we0     <= w_v0 ? w_o0.we  : 8'h00;
            we1     <= w_v1 ? w_o1.we  : 8'h00;
            wa0     <= w_v0 ? w_o0.tag : '0;
            wa1     <= w_v1 ? w_o1.tag : '0;
            i0      <= w_v0 ? w_o0.dat : '0;
            i1      <= w_v1 ? w_o1.dat : '0;
        end
    end

    assign count = r_count;
    assign empty = (r_count == '0) && !wr0 && !wr1;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (r_count <= CW'(DEPTH))
                else $error("thor2024_wb_queue: count exceeds DEPTH");
        end
    end

endmodule

`default_nettype wire
